// File: rtl/execute_pkg.sv
// execute_pkg: ALU, M-extension, forwarding and branch encodings plus divider FSM states
package execute_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;
  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [2:0] BR_EQ     = 3'b000;
  localparam logic [2:0] BR_NE     = 3'b001;
  localparam logic [2:0] BR_NONE   = 3'b010;
  localparam logic [2:0] BR_ALWAYS = 3'b011;
  localparam logic [2:0] BR_LT     = 3'b100;
  localparam logic [2:0] BR_GE     = 3'b101;
  localparam logic [2:0] BR_LTU    = 3'b110;
  localparam logic [2:0] BR_GEU    = 3'b111;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational integer ALU
// ports: a, b operands; ctrl ALU op; y result
module alu import execute_pkg::*; #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [W-1:0] y
);
  localparam int SW = $clog2(W);
  logic [W-1:0] sra;
  logic lt, ltu;
  always_comb begin
    sra = $signed(a) >>> b[SW-1:0];
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    y = ctrl == ALU_ADD  ? a + b :
        ctrl == ALU_SUB  ? a - b :
        ctrl == ALU_AND  ? a & b :
        ctrl == ALU_OR   ? a | b :
        ctrl == ALU_XOR  ? a ^ b :
        ctrl == ALU_SLT  ? {{(W-1){1'b0}}, lt} :
        ctrl == ALU_SLTU ? {{(W-1){1'b0}}, ltu} :
        ctrl == ALU_SLL  ? a << b[SW-1:0] :
        ctrl == ALU_SRL  ? a >> b[SW-1:0] :
        ctrl == ALU_SRA  ? sra : '0;
  end
endmodule

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, IDLE/BUSY/DONE, one quotient bit per cycle
// ports: start/flush control, sgn signed mode, a dividend, b divisor; busy/done state, quotient, remainder
module div_iter import execute_pkg::*; #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic         sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  div_state_t state;
  logic [CW-1:0] cnt;
  logic [W-1:0] q, r, d, ma, mb;
  logic [W:0] sh, diff;
  logic sa, sb, zero, ovf, neg_q, neg_r, special;
  always_comb begin
    sa = sgn & a[W-1];
    sb = sgn & b[W-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    zero = b == '0;
    ovf = sgn && a == MIN && b == '1;
    sh = {r, q[W-1]};
    diff = sh - {1'b0, d};
    busy = state == BUSY;
    done = state == DONE;
    // special-case results are final as latched; only magnitudes get the sign fix-up
    quotient = special | !neg_q ? q : -q;
    remainder = special | !neg_r ? r : -r;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      q <= '0;
      r <= '0;
      d <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      special <= 1'b0;
    end else if (flush) state <= IDLE;
    else case (state)
      IDLE: if (start) begin
        neg_q <= sa ^ sb;
        neg_r <= sa;
        d <= mb;
        cnt <= CW'(W);
        special <= zero | ovf;
        q <= zero ? '1 : ovf ? MIN : ma;
        r <= zero ? a : '0;
        state <= zero | ovf ? DONE : BUSY;
      end
      BUSY: begin
        q <= {q[W-2:0], !diff[W]};
        r <= diff[W] ? sh[W-1:0] : diff[W-1:0];
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) state <= DONE;
      end
      default: state <= IDLE;
    endcase
endmodule

// File: rtl/execute_mext.sv
// execute_mext: RV32 execute stage with forwarding, branch resolution and RV32M multiply/divide
// ports: operands/PC/imm/forward values in, ALU and hazard control in, register ids passed through,
//        ALU result / store data / PC+4 / target / branch taken out, StallE_o while a divide runs
module execute_mext import execute_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int FWD_SRCS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RD1E_i,
  input  logic [DATA_WIDTH-1:0] RD2E_i,
  input  logic [DATA_WIDTH-1:0] PCE_i,
  input  logic [DATA_WIDTH-1:0] ImmExtE_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
  input  logic [DATA_WIDTH-1:0] ResultW_i,
  input  logic [DATA_WIDTH-1:0] ALUResultM_i,
  input  logic [3:0]            ALUCtrl_i,
  input  logic                  ALUSrcA_i,
  input  logic                  ALUSrcB_i,
  input  logic                  JumpCtrl_i,
  input  logic [2:0]            BranchSrc_i,
  input  logic                  MExt_i,
  input  logic [2:0]            MOp_i,
  input  logic [1:0]            ForwardAEctrl_i,
  input  logic [1:0]            ForwardBEctrl_i,
  input  logic                  FlushE_i,
  output logic                  StallE_o,
  input  logic [4:0]            RdD_i,
  input  logic [4:0]            Rs1D_i,
  input  logic [4:0]            Rs2D_i,
  output logic [4:0]            RdE_o,
  output logic [4:0]            Rs1E_o,
  output logic [4:0]            Rs2E_o,
  output logic [DATA_WIDTH-1:0] ALUResultE_o,
  output logic [DATA_WIDTH-1:0] WriteDataE_o,
  output logic [DATA_WIDTH-1:0] PCPlus4E_o,
  output logic [DATA_WIDTH-1:0] PCTargetE_o,
  output logic                  branchTaken_o
);
  localparam int W = DATA_WIDTH;
  logic [W-1:0] fa, fb, src_a, src_b, alu_y, mul_y, quo, rem;
  logic [2*W-1:0] prod;
  logic a_sgn, b_sgn, start, busy, done, rem_q, eq, lt, ltu, br;
  alu #(.W(W)) u_alu (.a(src_a), .b(src_b), .ctrl(ALUCtrl_i), .y(alu_y));
  div_iter #(.W(W)) u_div (
    .clk(clk), .rst(rst), .start(start), .flush(FlushE_i), .sgn(!MOp_i[0]),
    .a(src_a), .b(src_b), .busy(busy), .done(done), .quotient(quo), .remainder(rem)
  );
  always_comb begin
    // unsupported select codes (11, or sources beyond FWD_SRCS) fall back to the register value
    fa = ForwardAEctrl_i == FWD_W && FWD_SRCS > 1 ? ResultW_i :
         ForwardAEctrl_i == FWD_M && FWD_SRCS > 2 ? ALUResultM_i : RD1E_i;
    fb = ForwardBEctrl_i == FWD_W && FWD_SRCS > 1 ? ResultW_i :
         ForwardBEctrl_i == FWD_M && FWD_SRCS > 2 ? ALUResultM_i : RD2E_i;
    src_a = ALUSrcA_i ? PCE_i : fa;
    src_b = ALUSrcB_i ? ImmExtE_i : fb;
    a_sgn = src_a[W-1] & (MOp_i != M_MULHU);
    b_sgn = src_b[W-1] & (MOp_i == M_MUL || MOp_i == M_MULH);
    prod = {{W{a_sgn}}, src_a} * {{W{b_sgn}}, src_b};
    mul_y = MOp_i == M_MUL ? prod[W-1:0] : prod[2*W-1:W];
    start = MExt_i & MOp_i[2] & !FlushE_i & !busy & !done;
    StallE_o = !rst & (start | busy & !FlushE_i);
    eq = fa == fb;
    lt = $signed(fa) < $signed(fb);
    ltu = fa < fb;
    // bit0 inverts the base condition; 01x is never/always
    br = BranchSrc_i[2] ? (BranchSrc_i[1] ? ltu : lt) ^ BranchSrc_i[0] :
         BranchSrc_i[1] ? BranchSrc_i[0] : eq ^ BranchSrc_i[0];
    branchTaken_o = br & !MExt_i;
    ALUResultE_o = !MExt_i ? alu_y : !MOp_i[2] ? mul_y : rem_q ? rem : quo;
    PCTargetE_o = JumpCtrl_i ? alu_y : PCE_i + ImmExtE_i;
    WriteDataE_o = fb;
    PCPlus4E_o = PCPlus4E_i;
    RdE_o = RdD_i;
    Rs1E_o = Rs1D_i;
    Rs2E_o = Rs2D_i;
  end
  always_ff @(posedge clk)
    rem_q <= rst ? 1'b0 : start ? MOp_i[1] : rem_q;
endmodule

// File: tb/tb_execute_mext.sv
// tb_execute_mext: directed scoreboard bench for execute_mext
module tb_execute_mext;
  import execute_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] RD1E_i, RD2E_i, PCE_i, ImmExtE_i, PCPlus4E_i, ResultW_i, ALUResultM_i;
  logic [3:0] ALUCtrl_i;
  logic ALUSrcA_i, ALUSrcB_i, JumpCtrl_i, MExt_i, FlushE_i, StallE_o, branchTaken_o;
  logic [2:0] BranchSrc_i, MOp_i;
  logic [1:0] ForwardAEctrl_i, ForwardBEctrl_i;
  logic [4:0] RdD_i, Rs1D_i, Rs2D_i, RdE_o, Rs1E_o, Rs2E_o;
  logic [W-1:0] ALUResultE_o, WriteDataE_o, PCPlus4E_o, PCTargetE_o;

  always #5 clk = ~clk;

  execute_mext #(.DATA_WIDTH(W), .FWD_SRCS(3)) dut (
    .clk(clk), .rst(rst), .RD1E_i(RD1E_i), .RD2E_i(RD2E_i), .PCE_i(PCE_i),
    .ImmExtE_i(ImmExtE_i), .PCPlus4E_i(PCPlus4E_i), .ResultW_i(ResultW_i),
    .ALUResultM_i(ALUResultM_i), .ALUCtrl_i(ALUCtrl_i), .ALUSrcA_i(ALUSrcA_i),
    .ALUSrcB_i(ALUSrcB_i), .JumpCtrl_i(JumpCtrl_i), .BranchSrc_i(BranchSrc_i),
    .MExt_i(MExt_i), .MOp_i(MOp_i), .ForwardAEctrl_i(ForwardAEctrl_i),
    .ForwardBEctrl_i(ForwardBEctrl_i), .FlushE_i(FlushE_i), .StallE_o(StallE_o),
    .RdD_i(RdD_i), .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .RdE_o(RdE_o), .Rs1E_o(Rs1E_o),
    .Rs2E_o(Rs2E_o), .ALUResultE_o(ALUResultE_o), .WriteDataE_o(WriteDataE_o),
    .PCPlus4E_o(PCPlus4E_o), .PCTargetE_o(PCTargetE_o), .branchTaken_o(branchTaken_o)
  );

  typedef struct {
    string tag;
    logic [W-1:0] res;
    int stalls;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0, stall_sum = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [W-1:0] ref_m(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] x, y;
    logic [63:0] p;
    x = a;
    y = b;
    p = longint'(x) * longint'(y);
    if (op == M_MULHSU) p = longint'(x) * longint'({32'b0, b});
    if (op == M_MULHU) p = {32'b0, a} * {32'b0, b};
    if (op == M_MUL) return a * b;
    if (!op[2]) return p[63:32];
    if (b == 0) return op[1] ? a : '1;
    if (!op[0] && a == 32'h8000_0000 && b == '1) return op[1] ? '0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? x % y : x / y;
    return op[1] ? a % b : a / b;
  endfunction

  function automatic int ref_st(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (!op[2]) return 0;
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == '1)) return 1;
    return W + 1;
  endfunction

  task automatic drive(input logic mext, input logic [2:0] op, input logic [3:0] ctrl,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    MExt_i = mext; MOp_i = op; ALUCtrl_i = ctrl; RD1E_i = a; RD2E_i = b;
    ForwardAEctrl_i = FWD_REG; ForwardBEctrl_i = FWD_REG; ALUSrcA_i = 1'b0; ALUSrcB_i = 1'b0;
    JumpCtrl_i = 1'b0; BranchSrc_i = BR_NONE; FlushE_i = 1'b0;
  endtask

  task automatic push(input string tag, input logic [W-1:0] res, input int st);
    exp_t e;
    e.tag = tag; e.res = res; e.stalls = st;
    sb.push_back(e);
  endtask

  task automatic issue_k(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] res, input int st);
    drive(1'b1, op, ALU_ADD, a, b);
    push(tag, res, st);
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue_k(tag, op, a, b, ref_m(op, a, b), ref_st(op, a, b));
  endtask

  task automatic issue_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    drive(1'b0, M_MUL, ALU_ADD, a, b);
    push(tag, a + b, 0);
  endtask

  // counts stall cycles (pre already seen), then checks latency and result in the release cycle
  task automatic retire(input int pre);
    exp_t e;
    int n;
    n = pre;
    e = sb.pop_front();
    @(negedge clk);
    while (StallE_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    stall_sum += n;
    chk({e.tag, "_stalls"}, 32'(n), 32'(e.stalls));
    chk(e.tag, ALUResultE_o, e.res);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    PCE_i = '0; ImmExtE_i = '0; PCPlus4E_i = '0; ResultW_i = '0; ALUResultM_i = '0;
    RdD_i = 5'd7; Rs1D_i = 5'd12; Rs2D_i = 5'd31;
    drive(1'b1, M_DIV, ALU_ADD, 32'd100, 32'hFFFF_FFF9);
    @(negedge clk);
    chk("rst_stall", 32'(StallE_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    PCPlus4E_i = 32'h0000_0104;
    drive(1'b0, M_MUL, ALU_SUB, 32'd50, 32'd8);
    @(negedge clk);
    chk("sub", ALUResultE_o, 32'd42);
    chk("wdata", WriteDataE_o, 32'd8);
    chk("pc4", PCPlus4E_o, 32'h0000_0104);
    chk("rd_pass", 32'(RdE_o), 32'd7);
    chk("rs2_pass", 32'(Rs2E_o), 32'd31);
    chk("alu_stall", 32'(StallE_o), 32'd0);
    @(posedge clk);
    #1;
    issue_add("add", 32'd5, 32'd7);
    retire(0);
    issue_k("div_100_m7", M_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    retire(0);
    issue_k("rem_100_m7", M_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);
    retire(0);
    issue_k("divu_by0", M_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    retire(0);
    issue_k("rem_ovf", M_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    retire(0);
    issue("div_ovf", M_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    retire(0);
    issue("rem_by0", M_REM, 32'hFFFF_FF00, 32'd0);
    retire(0);
    issue_k("mulh_min", M_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    retire(0);
    issue_k("mulhu", M_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, 0);
    retire(0);
    issue("mul", M_MUL, 32'hFFFF_FFFD, 32'd7);
    retire(0);
    issue("mulhsu", M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    retire(0);
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom >> (i * 7);
      issue("div_rand", {1'b1, 2'(i)}, a, b);
      retire(0);
    end
    // dividend forwarded from M at start; M changing later must not disturb the divide
    issue_k("div_fwd_m", M_DIV, 32'hDEAD_BEEF, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    ForwardAEctrl_i = FWD_M;
    ALUResultM_i = 32'd100;
    @(negedge clk);
    chk("fwd_start_stall", 32'(StallE_o), 32'd1);
    @(posedge clk);
    #1 ALUResultM_i = 32'd5;
    retire(1);
    drive(1'b1, M_DIV, ALU_ADD, 32'd1000, 32'd3);
    @(negedge clk);
    chk("flush_start_stall", 32'(StallE_o), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_stall", 32'(StallE_o), 32'd1);
    FlushE_i = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(StallE_o), 32'd0);
    @(posedge clk);
    #1;
    issue_add("add_after_flush", 32'd20, 32'd22);
    retire(0);
    stall_sum = 0;
    issue_k("divu_7_2_a", M_DIVU, 32'd7, 32'd2, 32'd3, 33);
    push("divu_7_2_b", 32'd3, 33);
    retire(0);
    retire(0);
    chk("b2b_stall_total", 32'(stall_sum), 32'd66);
    drive(1'b1, M_DIVU, ALU_ADD, 32'd99, 32'd4);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy_stall", 32'(StallE_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    issue_add("add_after_rst", 32'd1, 32'd2);
    retire(0);
    drive(1'b0, M_MUL, ALU_ADD, 32'd3, 32'd4);
    ResultW_i = 32'd100;
    ALUResultM_i = 32'd200;
    ForwardAEctrl_i = 2'b11;
    @(negedge clk);
    chk("fwd_11_reg", ALUResultE_o, 32'd7);
    #1 ForwardAEctrl_i = FWD_W;
    ForwardBEctrl_i = FWD_M;
    @(negedge clk);
    chk("fwd_w_m", ALUResultE_o, 32'd300);
    drive(1'b0, M_MUL, ALU_ADD, 32'h55, 32'h55);
    BranchSrc_i = BR_EQ;
    PCE_i = 32'h0000_1000;
    ImmExtE_i = 32'h0000_0020;
    @(negedge clk);
    chk("beq_taken", 32'(branchTaken_o), 32'd1);
    chk("pctarget_br", PCTargetE_o, 32'h0000_1020);
    #1 BranchSrc_i = BR_LT;
    RD1E_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("blt_signed", 32'(branchTaken_o), 32'd1);
    #1 BranchSrc_i = BR_LTU;
    @(negedge clk);
    chk("bltu_unsigned", 32'(branchTaken_o), 32'd0);
    #1 BranchSrc_i = BR_EQ;
    RD1E_i = 32'h55;
    MExt_i = 1'b1;
    @(negedge clk);
    chk("mext_no_branch", 32'(branchTaken_o), 32'd0);
    #1 drive(1'b0, M_MUL, ALU_ADD, 32'h0000_4000, 32'd0);
    ALUSrcB_i = 1'b1;
    JumpCtrl_i = 1'b1;
    BranchSrc_i = BR_ALWAYS;
    @(negedge clk);
    chk("jalr_target", PCTargetE_o, 32'h0000_4020);
    chk("jalr_taken", 32'(branchTaken_o), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/execute_mext.md
EXECUTE_MEXT -- requirements
Module: execute_mext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width (even, >=8).
REQ-002 SHALL have parameter FWD_SRCS, default 3, forwarding mux inputs (RD, ResultW, ALUResultM).
REQ-003 SHALL have one clock and synchronous active-high reset. Ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 Data ports: RD1E_i / RD2E_i / PCE_i / ImmExtE_i / PCPlus4E_i / ResultW_i / ALUResultM_i  in  DATA_WIDTH  register operands, PC, immediate, PC+4, W and M forwarding values.
REQ-005 Control ports: ALUCtrl_i  in  4  ALU op; ALUSrcA_i  in  1  SrcA = PCE_i; ALUSrcB_i  in  1  SrcB = ImmExtE_i; JumpCtrl_i  in  1  target = ALU result; BranchSrc_i  in  3  branch condition.
REQ-006 M-extension ports: MExt_i  in  1  instruction is RV32M; MOp_i  in  3  funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 Hazard ports: ForwardAEctrl_i / ForwardBEctrl_i  in  2  00 reg, 01 ResultW, 10 ALUResultM; FlushE_i  in  1  kill E instruction; StallE_o  out  1  freeze F/D/E, bubble into M.
REQ-008 Register ports: RdD_i / Rs1D_i / Rs2D_i  in  5; RdE_o / Rs1E_o / Rs2E_o  out  5  pass-through.
REQ-009 Result ports: ALUResultE_o / WriteDataE_o / PCPlus4E_o / PCTargetE_o  out  DATA_WIDTH; branchTaken_o  out  1.

Function
REQ-010 Forwarding muxes SHALL select per REQ-007; code 11 SHALL select the register value.
REQ-011 Non-M instructions SHALL behave as a single-cycle execute: existing ALU instance, PCTargetE_o = JumpCtrl_i ? ALU result : PCE_i + ImmExtE_i, StallE_o = 0.
REQ-012 MUL* SHALL complete combinationally in one cycle from a 2*DATA_WIDTH product; MUL returns low half, others high half with the signedness MOp_i implies; StallE_o = 0.
REQ-013 DIV/DIVU/REM/REMU SHALL use an FSM with states IDLE, BUSY, DONE.
REQ-014 In IDLE, when MExt_i & MOp_i[2] & !FlushE_i, the block SHALL assert StallE_o combinationally and latch the forwarded SrcA/SrcB, MOp_i, and operand signs.
REQ-015 From IDLE, divisor 0 or signed overflow (DIV/REM with MIN / -1) SHALL go directly to DONE; otherwise the FSM SHALL go to BUSY with iteration counter = DATA_WIDTH.
REQ-016 BUSY SHALL perform one restoring-division step per cycle on unsigned magnitudes, decrement the counter, hold StallE_o = 1, and go to DONE when the counter reaches 1.
REQ-017 DONE SHALL drive StallE_o = 0 and the final result on ALUResultE_o for one cycle, then go to IDLE without restarting on the same instruction.
REQ-018 Normal division latency SHALL be DATA_WIDTH+1 stall cycles; special cases SHALL take 1 stall cycle.
REQ-019 Divide by zero SHALL give quotient all-ones and remainder = dividend; overflow SHALL give quotient = MIN and remainder 0.
REQ-020 Signed results SHALL take quotient sign = sign(A) xor sign(B) and remainder sign = sign(A).
REQ-021 FlushE_i in BUSY or DONE SHALL return the FSM to IDLE next cycle, with StallE_o = 0 in the flush cycle.
REQ-022 Back-to-back divides SHALL start the second divide in the IDLE cycle after DONE.
REQ-023 branchTaken_o SHALL be 0 whenever MExt_i = 1.

Reset
REQ-024 rst SHALL put the FSM in IDLE and clear the counter and latched operands; StallE_o is 0 in the reset cycle. Combinational outputs follow their inputs.
REQ-025 rst asserted during BUSY SHALL abort the divide with no result.

Structure
REQ-026 Package execute_pkg SHALL hold the ALUCtrl encodings, MOp encodings, forward-select codes, and the div_state_t enum.
REQ-027 The iterative divider SHALL be sub-module div_iter (start, sign mode, operands, busy, done, quotient, remainder); the ALU is reused unchanged.

Verification
REQ-028 DIV 100 / -7 -> StallE_o high for 33 cycles, then ALUResultE_o = -14 (0xFFFFFFF2); REM gives 2.
REQ-029 DIVU x / 0 -> 1 stall cycle, result 0xFFFFFFFF; REM 0x80000000 / 0xFFFFFFFF -> result 0, 1 stall cycle.
REQ-030 MULH 0x80000000 * 0x80000000 -> result 0x40000000, StallE_o = 0; MULHU 0xFFFFFFFF * 2 -> 1.
REQ-031 DIV with ForwardAEctrl_i = 10 at start, then ALUResultM_i changes during BUSY -> result uses the latched value.
REQ-032 FlushE_i at BUSY cycle 10 -> StallE_o = 0 that cycle, FSM in IDLE next cycle; a following ADD completes in one cycle.
REQ-033 Two consecutive DIVU 7/2 -> results 3 and 3; 66 stall cycles total; second start one cycle after the first DONE.
